// File: rtl/uart_alu_pkg.sv
// Shared opcodes, header length and parser state encoding for the UART ALU controller.
package uart_alu_pkg;

  localparam logic [7:0]  OpEcho = 8'hEC;
  localparam logic [7:0]  OpAdd  = 8'hAD;
  localparam logic [7:0]  OpMul  = 8'h88;
  localparam logic [15:0] HdrLen = 16'd4;

  typedef enum logic [2:0] {
    StOpcode,
    StRsvd,
    StLenLo,
    StLenHi,
    StEcho,
    StAccum,
    StResult,
    StDrain
  } state_e;

endpackage

// File: rtl/uart_alu_accum.sv
// Little-endian 32-bit word assembly and running add (or multiply, with UART_ALU_MUL_EN) accumulator.
module uart_alu_accum
  import uart_alu_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        init_i,
  input  logic        mul_i,
  input  logic        valid_i,
  input  logic [7:0]  data_i,
  output logic [31:0] acc_o
);

  logic [23:0] part_q;
  logic [1:0]  idx_q;
  logic [31:0] acc_q;
  logic [31:0] word;

  // The fourth byte completes the word directly from the input, so no extra cycle is needed.
  assign word  = {data_i, part_q};
  assign acc_o = acc_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      part_q <= '0;
      idx_q  <= '0;
      acc_q  <= '0;
    end else if (init_i) begin
      part_q <= '0;
      idx_q  <= '0;
      acc_q  <= {31'd0, mul_i};
    end else if (valid_i) begin
      idx_q  <= idx_q + 2'd1;
      part_q <= {data_i, part_q[23:8]};
      if (idx_q == 2'd3) begin
`ifdef UART_ALU_MUL_EN
        acc_q <= mul_i ? acc_q * word : acc_q + word;
`else
        acc_q <= acc_q + word;
`endif
      end
    end
  end

endmodule

// File: rtl/uart_alu_ctrl.sv
// Packet parser between a UART byte stream and an echo / add32 engine.
// Define UART_ALU_MUL_EN to also accept opcode 0x88 (mul32).
module uart_alu_ctrl
  import uart_alu_pkg::*;
#(
  parameter logic [15:0] MaxLen = 16'd1024
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] s_axis_tdata_i,
  input  logic       s_axis_tvalid_i,
  output logic       s_axis_tready_o,
  output logic [7:0] m_axis_tdata_o,
  output logic       m_axis_tvalid_o,
  input  logic       m_axis_tready_i,
  output logic       busy_o,
  output logic       err_o
);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  op_q, op_d;
  logic [7:0]  len_lo_q, len_lo_d;
  logic [1:0]  idx_q, idx_d;
  logic        m_valid_q, m_valid_d;
  logic [7:0]  m_data_q, m_data_d;
  logic        err_q, err_d;

  logic        s_ready, s_hs;
  logic        acc_init, acc_en;
  logic        is_mul, is_arith;
  logic [15:0] len, payload;
  logic [1:0]  idx_inc;
  logic [31:0] acc;

`ifdef UART_ALU_MUL_EN
  assign is_mul = (op_q == OpMul);
`else
  assign is_mul = 1'b0;
`endif
  assign is_arith = (op_q == OpAdd) || is_mul;
  assign len      = {s_axis_tdata_i, len_lo_q};
  assign payload  = len - HdrLen;
  assign idx_inc  = idx_q + 2'd1;
  assign s_hs     = s_axis_tvalid_i && s_ready;

  // Echo stops accepting once its count is exhausted so the last byte can drain before OPCODE.
  always_comb begin
    s_ready = 1'b1;
    if (state_q == StResult) s_ready = 1'b0;
    else if (state_q == StEcho) s_ready = (cnt_q != 16'd0) && (!m_valid_q || m_axis_tready_i);
  end

  uart_alu_accum u_accum (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .init_i  (acc_init),
    .mul_i   (is_mul),
    .valid_i (acc_en),
    .data_i  (s_axis_tdata_i),
    .acc_o   (acc)
  );

  // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    len_lo_d  = len_lo_q;
    idx_d     = idx_q;
    m_valid_d = m_valid_q && !m_axis_tready_i;
    m_data_d  = m_data_q;
    err_d     = 1'b0;
    acc_init  = 1'b0;
    acc_en    = 1'b0;
    unique case (state_q)
      StOpcode: if (s_hs) begin op_d = s_axis_tdata_i; state_d = StRsvd; end
      StRsvd:   if (s_hs) state_d = StLenLo;
      StLenLo:  if (s_hs) begin len_lo_d = s_axis_tdata_i; state_d = StLenHi; end
      StLenHi: if (s_hs) begin
        cnt_d    = payload;
        idx_d    = 2'd0;
        acc_init = 1'b1;
        if (len < HdrLen || len > MaxLen) begin
          err_d   = 1'b1;
          state_d = StOpcode;
        end else if (op_q == OpEcho) begin
          state_d = (payload == 16'd0) ? StOpcode : StEcho;
        end else if (is_arith) begin
          if (payload[1:0] != 2'b00) begin
            err_d   = 1'b1;
            state_d = StDrain;
          end else begin
            state_d = (payload == 16'd0) ? StResult : StAccum;
          end
        end else begin
          err_d   = 1'b1;
          state_d = (payload == 16'd0) ? StOpcode : StDrain;
        end
      end
      StEcho: begin
        if (cnt_q != 16'd0) begin
          if (s_hs) begin
            m_data_d  = s_axis_tdata_i;
            m_valid_d = 1'b1;
            cnt_d     = cnt_q - 16'd1;
          end
        end else if (!m_valid_q || m_axis_tready_i) begin
          state_d = StOpcode;
        end
      end
      StAccum: if (s_hs) begin
        acc_en = 1'b1;
        cnt_d  = cnt_q - 16'd1;
        if (cnt_q == 16'd1) state_d = StResult;
      end
      StResult: begin
        if (!m_valid_q) begin
          m_valid_d = 1'b1;
          m_data_d  = acc[{idx_q, 3'b000} +: 8];
        end else if (m_axis_tready_i) begin
          if (idx_q == 2'd3) begin
            state_d = StOpcode;
          end else begin
            idx_d     = idx_inc;
            m_valid_d = 1'b1;
            m_data_d  = acc[{idx_inc, 3'b000} +: 8];
          end
        end
      end
      StDrain: if (s_hs) begin
        cnt_d = cnt_q - 16'd1;
        if (cnt_q == 16'd1) state_d = StOpcode;
      end
      default: state_d = StOpcode;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StOpcode;
      cnt_q     <= '0;
      op_q      <= '0;
      len_lo_q  <= '0;
      idx_q     <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      len_lo_q  <= len_lo_d;
      idx_q     <= idx_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      err_q     <= err_d;
    end
  end

  assign s_axis_tready_o = s_ready;
  assign m_axis_tdata_o  = m_data_q;
  assign m_axis_tvalid_o = m_valid_q;
  assign busy_o          = (state_q != StOpcode);
  assign err_o           = err_q;

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Bench for uart_alu_ctrl: directed packets plus random traffic against a packet-level reference model.
module tb_uart_alu_ctrl;

  localparam int MAX_LEN = 1024;
`ifdef UART_ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_ni;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       busy;
  logic       err;

  int checks = 0;
  int errors = 0;
  int err_seen = 0;
  int exp_err = 0;
  int rdy_mode = 0;
  int cyc = 0;
  bit gaps = 1'b0;

  logic [7:0] pkt[$];
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  uart_alu_ctrl #(.MaxLen(16'd1024)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .s_axis_tdata_i  (s_data),
    .s_axis_tvalid_i (s_valid),
    .s_axis_tready_o (s_ready),
    .m_axis_tdata_o  (m_data),
    .m_axis_tvalid_o (m_valid),
    .m_axis_tready_i (m_ready),
    .busy_o          (busy),
    .err_o           (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Downstream ready pattern: 0 always, 1 random, 2 one cycle in three, 3 never.
  initial begin
    m_ready = 1'b1;
    forever begin
      @(negedge clk);
      cyc++;
      case (rdy_mode)
        0:       m_ready = 1'b1;
        1:       m_ready = 1'($urandom_range(0, 1));
        2:       m_ready = (cyc % 3 == 0);
        default: m_ready = 1'b0;
      endcase
    end
  end

  // Compare process: every downstream handshake against the model, plus hold-while-stalled.
  initial begin
    bit         stall;
    logic [7:0] held;
    logic [7:0] e;
    stall = 1'b0;
    held  = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_ni) begin
        stall = 1'b0;
      end else begin
        if (err) err_seen++;
        if (stall) begin
          check("tvalid held while stalled", m_valid, 1);
          check("tdata stable while stalled", m_data, held);
        end
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected output: got %02h expected none", m_data);
          end else begin
            e = exp_q.pop_front();
            check("output byte", m_data, e);
          end
          got_q.push_back(m_data);
        end
        stall = m_valid && !m_ready;
        held  = m_data;
      end
    end
  end

  // Packet-level reference: what a whole packet must produce, from the packet rules alone.
  task automatic model();
    int          len;
    int          pl;
    logic [7:0]  op;
    logic [31:0] acc;
    logic [31:0] word;
    bit          mul;
    op  = pkt[0];
    len = int'({pkt[3], pkt[2]});
    pl  = len - 4;
    mul = MUL_EN && (op == 8'h88);
    if (len < 4 || len > MAX_LEN) begin
      exp_err++;
    end else if (op == 8'hEC) begin
      for (int i = 0; i < pl; i++) exp_q.push_back(pkt[4 + i]);
    end else if (op == 8'hAD || mul) begin
      if (pl % 4 != 0) begin
        exp_err++;
      end else begin
        acc = mul ? 32'd1 : 32'd0;
        for (int k = 4; k < len; k += 4) begin
          word = {pkt[k + 3], pkt[k + 2], pkt[k + 1], pkt[k]};
          acc  = mul ? acc * word : acc + word;
        end
        for (int b = 0; b < 4; b++) exp_q.push_back(8'(acc >> (8 * b)));
      end
    end else begin
      exp_err++;
    end
  endtask

  task automatic send();
    foreach (pkt[i]) begin
      int n;
      if (gaps && $urandom_range(0, 3) == 0) begin
        @(negedge clk);
        s_valid = 1'b0;
      end
      @(negedge clk);
      s_data  = pkt[i];
      s_valid = 1'b1;
      #1;
      n = 0;
      while (!s_ready && n < 2000) begin
        @(negedge clk);
        #1;
        n++;
      end
      if (n >= 2000) begin
        checks++;
        errors++;
        $display("FAIL s_ready timeout: byte %0d never accepted", i);
        s_valid = 1'b0;
        return;
      end
    end
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge clk);
    #3;
    while ((busy || m_valid) && n < 5000) begin
      @(negedge clk);
      #3;
      n++;
    end
    check({name, " returns idle"}, busy, 0);
    check({name, " all expected bytes seen"}, exp_q.size(), 0);
    check({name, " err pulse count"}, err_seen, exp_err);
  endtask

  task automatic run(input string name);
    got_q.delete();
    model();
    send();
    wait_idle(name);
  endtask

  task automatic load(input logic [127:0] v, input int n);
    pkt.delete();
    for (int i = 0; i < n; i++) pkt.push_back(v[8 * (n - 1 - i) +: 8]);
  endtask

  function automatic logic [31:0] got_word();
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < got_q.size() && i < 4; i++) w[8 * i +: 8] = got_q[i];
    return w;
  endfunction

  task automatic rand_pkt();
    int         kind;
    int         len;
    logic [7:0] op;
    kind = $urandom_range(0, 9);
    case ($urandom_range(0, 3))
      0:       op = 8'hEC;
      1:       op = 8'hAD;
      2:       op = 8'h88;
      default: op = 8'($urandom);
    endcase
    if (kind == 0)      len = $urandom_range(0, 3);
    else if (kind == 1) len = MAX_LEN + $urandom_range(1, 100);
    else if (op == 8'hEC) len = 4 + $urandom_range(0, 24);
    else len = 4 + 4 * $urandom_range(0, 6) + ((kind == 2) ? $urandom_range(1, 3) : 0);
    pkt.delete();
    pkt.push_back(op);
    pkt.push_back(8'($urandom));
    pkt.push_back(len[7:0]);
    pkt.push_back(len[15:8]);
    if (len >= 4 && len <= MAX_LEN)
      for (int i = 0; i < len - 4; i++) pkt.push_back(8'($urandom));
  endtask

  initial begin
    int e0;
    rst_ni  = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    repeat (3) @(negedge clk);
    #1;
    check("reset tvalid", m_valid, 0);
    check("reset tdata", m_data, 0);
    check("reset err", err, 0);
    check("reset busy", busy, 0);
    check("reset s_ready", s_ready, 1);
    @(negedge clk);
    rst_ni = 1'b1;

    load(128'hEC_00_08_00_DE_AD_BE_EF, 8);
    run("echo");
    check("echo byte count", got_q.size(), 4);
    check("echo bytes", got_word(), 32'hEFBEADDE);

    load(128'hAD_00_0C_00_01_00_00_00_FF_FF_FF_FF, 12);
    run("add wrap");
    check("add wrap byte count", got_q.size(), 4);
    check("add wrap result", got_word(), 32'h0000_0000);

    load(128'hAD_00_0C_00_01_00_00_00_02_00_00_00, 12);
    run("add");
    check("add result", got_word(), 32'h0000_0003);

    e0 = err_seen;
    load(128'h55_00_06_00_11_22, 6);
    run("unknown opcode");
    check("unknown opcode err pulses", err_seen - e0, 1);
    check("unknown opcode no output", got_q.size(), 0);
    load(128'hEC_00_06_00_12_34, 6);
    run("echo after error");
    check("echo after error bytes", got_word(), 32'h0000_3412);

    e0 = err_seen;
    load(128'hAD_00_07_00_AA_BB_CC, 7);
    run("add bad length");
    check("add bad length err pulses", err_seen - e0, 1);
    check("add bad length no output", got_q.size(), 0);

    e0 = err_seen;
    load(128'hEC_00_04_00, 4);
    run("echo empty");
    check("echo empty no output", got_q.size(), 0);
    check("echo empty no error", err_seen - e0, 0);
    load(128'hAD_00_04_00, 4);
    run("add empty");
    check("add empty result", got_word(), 32'h0000_0000);
    e0 = err_seen;
    load(128'hEC_00_03_00, 4);
    run("length 3");
    check("length 3 err pulses", err_seen - e0, 1);
    e0 = err_seen;
    load(128'hEC_00_01_04, 4);
    run("length MaxLen+1");
    check("length MaxLen+1 err pulses", err_seen - e0, 1);

    rdy_mode = 2;
    pkt.delete();
    pkt.push_back(8'hEC); pkt.push_back(8'h00); pkt.push_back(8'd20); pkt.push_back(8'h00);
    for (int i = 0; i < 16; i++) pkt.push_back(8'($urandom));
    run("echo backpressure");
    check("echo backpressure byte count", got_q.size(), 16);

    rdy_mode = 1;
    pkt.delete();
    pkt.push_back(8'hEC); pkt.push_back(8'h5A); pkt.push_back(8'h00); pkt.push_back(8'h04);
    for (int i = 0; i < MAX_LEN - 4; i++) pkt.push_back(8'($urandom));
    run("echo MaxLen");
    check("echo MaxLen byte count", got_q.size(), MAX_LEN - 4);

    rdy_mode = 3;
    load(128'hEC_00_08_00_DE, 5);
    send();
    @(negedge clk);
    #1;
    check("pre-reset busy", busy, 1);
    rst_ni = 1'b0;
    #1;
    check("mid-packet reset tvalid", m_valid, 0);
    check("mid-packet reset tdata", m_data, 0);
    check("mid-packet reset err", err, 0);
    check("mid-packet reset busy", busy, 0);
    check("mid-packet reset s_ready", s_ready, 1);
    @(negedge clk);
    rst_ni   = 1'b1;
    rdy_mode = 0;
    load(128'hAD_00_04_00, 4);
    run("add after reset");
    check("add after reset byte count", got_q.size(), 4);
    check("add after reset result", got_word(), 32'h0000_0000);

    e0 = err_seen;
    load(128'h88_00_0C_00_03_00_00_00_05_00_00_00, 12);
    run("mul");
`ifdef UART_ALU_MUL_EN
    check("mul result", got_word(), 32'h0000_000F);
    check("mul no error", err_seen - e0, 0);
`else
    check("mul disabled no output", got_q.size(), 0);
    check("mul disabled err pulses", err_seen - e0, 1);
`endif

    gaps = 1'b1;
    for (int p = 0; p < 40; p++) begin
      rdy_mode = $urandom_range(0, 2);
      rand_pkt();
      run("random packet");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
